// File: rtl/digit_splitter_pkg.sv
// Shared types and constants for the binary-to-BCD digit splitter.
// Widths here fix the two-digit display path (0..99).
package digit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIN_W   = 7;
  localparam int MAX_VAL = 99;
  localparam int BCD_W   = 4;
  localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;

endpackage

// File: rtl/digit_splitter_if.sv
// Request/result bundle between a digit-splitter client (master) and the splitter (slave).
interface digit_splitter_if;
  import digit_pkg::*;

  logic [BIN_W-1:0] bin;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [BCD_W-1:0] dig1;
  logic [BCD_W-1:0] dig2;

  modport master (
    output bin, start,
    input  busy, done, err, dig1, dig2
  );

  modport slave (
    input  bin, start,
    output busy, done, err, dig1, dig2
  );

endinterface

// File: rtl/digit_splitter_adj3.sv
// Double-dabble nibble correction: add 3 to a BCD nibble of 5 or more before a shift.
module bcd_adj3
  import digit_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/digit_splitter.sv
// Sequential binary-to-two-digit BCD converter (double dabble, one bit per clock)
// with a start/busy/done handshake; out-of-range inputs saturate to 9/9 with err.
module digit_splitter
  import digit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  digit_splitter_if.slave  bus
);

  localparam int SR_W = 2*BCD_W + BIN_W;
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [2:0]       LAST_CNT = 3'(BIN_W-1);

  function automatic logic [2*BCD_W-1:0] sat_digits();
    return {SAT_DIGIT, SAT_DIGIT};
  endfunction

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_nxt;
  logic [BCD_W-1:0] tens_adj;
  logic [BCD_W-1:0] ones_adj;
  logic [BCD_W-1:0] dig1_q;
  logic [BCD_W-1:0] dig2_q;
  logic             err_q;
  logic             bad_in;
  logic             last;

  assign bad_in = bus.bin > MAX_BIN;
  assign last   = (cnt == LAST_CNT);

  bcd_adj3 u_adj_tens (
    .nib (sr[SR_W-1 -: BCD_W]),
    .adj (tens_adj)
  );

  bcd_adj3 u_adj_ones (
    .nib (sr[BIN_W +: BCD_W]),
    .adj (ones_adj)
  );

  assign sr_adj = {tens_adj, ones_adj, sr[BIN_W-1:0]};
  assign sr_nxt = sr_adj << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = bad_in ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Digits are captured on the edge that enters DONE, so they are valid with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr     <= '0;
      cnt    <= '0;
      dig1_q <= '0;
      dig2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bad_in) begin
              {dig2_q, dig1_q} <= sat_digits();
              err_q            <= 1'b1;
            end else begin
              sr  <= {{(2*BCD_W){1'b0}}, bus.bin};
              cnt <= '0;
            end
          end
        end
        SHIFT: begin
          sr  <= sr_nxt;
          cnt <= cnt + 3'd1;
          if (last) begin
            dig2_q <= sr_nxt[SR_W-1 -: BCD_W];
            dig1_q <= sr_nxt[BIN_W +: BCD_W];
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dig1 = dig1_q;
  assign bus.dig2 = dig2_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_digit_splitter.sv
// Scoreboard bench for digit_splitter: expected digits are queued at each accepted
// start and compared against the DUT whenever done pulses.
module tb_digit_splitter;
  import digit_pkg::*;

  typedef struct {
    int         bin;
    logic [3:0] d2;
    logic [3:0] d1;
    logic       err;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  logic done_prev;
  exp_t sb[$];
  int   done_cyc[$];

  digit_splitter_if io ();

  digit_splitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int joiner(input logic [3:0] d1, input logic [3:0] d2);
    return int'(d2) * 10 + int'(d1);
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    e.bin = v;
    if (v > 99) begin
      e.d2 = 4'd9; e.d1 = 4'd9; e.err = 1'b1;
    end else begin
      e.d2 = 4'(v / 10); e.d1 = 4'(v % 10); e.err = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (io.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dig2", int'(io.dig2), int'(e.d2));
        chk("dig1", int'(io.dig1), int'(e.d1));
        chk("err", int'(io.err), int'(e.err));
        if (!e.err) chk("join", joiner(io.dig1, io.dig2), e.bin);
      end
      done_cyc.push_back(cyc);
      done_cnt <= done_cnt + 1;
    end
    if (done_prev === 1'b1) chk("done_width", int'(io.done), 0);
    done_prev <= io.done;
  end

  // Drive one start pulse; returns at the negedge just after the sampling edge.
  task automatic go(input int v, input bit push);
    @(negedge clk);
    io.bin   = 7'(v);
    io.start = 1'b1;
    if (push) sb.push_back(model(v));
    @(negedge clk);
    io.start = 1'b0;
    io.bin   = 7'($urandom_range(0, 127));
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (io.done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    total = 0; bad = 0; cyc = 0; done_cnt = 0; done_prev = 1'b0;
    reset = 1'b1; io.start = 1'b0; io.bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(io.busy), 0);
    chk("rst_done", int'(io.done), 0);
    chk("rst_err", int'(io.err), 0);
    chk("rst_dig1", int'(io.dig1), 0);
    chk("rst_dig2", int'(io.dig2), 0);
    reset = 1'b0;
    @(negedge clk);

    // 26 -> 2/6 with 8-cycle latency
    go(26, 1'b1);
    chk("t1_busy", int'(io.busy), 1);
    wait_done(lat);
    chk("t1_latency", lat, 8);
    @(negedge clk);

    // 0 then 99 with start held high: accepts 9 cycles apart
    done_cyc.delete();
    @(negedge clk);
    io.bin = 7'd0; io.start = 1'b1; sb.push_back(model(0));
    @(negedge clk);
    io.bin = 7'd99; sb.push_back(model(99));
    wait_done(lat);
    chk("t2_lat0", lat, 8);
    @(negedge clk);
    @(negedge clk);
    io.start = 1'b0;
    wait_done(lat);
    chk("t2_lat99", lat, 8);
    @(negedge clk);
    chk("t2_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("t2_spacing", done_cyc[1] - done_cyc[0], 9);

    // out-of-range inputs saturate, a legal one clears err
    go(100, 1'b1);
    wait_done(lat);
    chk("t3_lat100", lat, 1);
    @(negedge clk);
    go(127, 1'b1);
    wait_done(lat);
    chk("t3_lat127", lat, 1);
    @(negedge clk);
    go(45, 1'b1);
    wait_done(lat);
    chk("t3_lat45", lat, 8);
    @(negedge clk);

    // start while busy is ignored
    base = done_cnt;
    go(26, 1'b1);
    @(negedge clk);
    @(negedge clk);
    io.start = 1'b1; io.bin = 7'd71;
    @(negedge clk);
    io.start = 1'b0;
    wait_done(lat);
    chk("t4_done_seen", int'(io.done), 1);
    repeat (12) @(negedge clk);
    chk("t4_one_done", done_cnt - base, 1);

    // reset mid-conversion aborts without a done pulse
    base = done_cnt;
    go(58, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", int'(io.busy), 0);
    chk("t5_done", int'(io.done), 0);
    chk("t5_dig1", int'(io.dig1), 0);
    chk("t5_dig2", int'(io.dig2), 0);
    chk("t5_err", int'(io.err), 0);
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_cnt - base, 0);
    go(13, 1'b1);
    wait_done(lat);
    chk("t5_lat13", lat, 8);
    @(negedge clk);

    // every legal value
    for (int v = 0; v <= 99; v++) begin
      go(v, 1'b1);
      wait_done(lat);
      chk("sweep_latency", lat, 8);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
